// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect requests and RAS push/pop in, fetch address and status out.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              EN;
  logic              Exc_Valid;
  logic              Branch_Taken;
  logic [ADDR_W-1:0] Branch_Target;
  logic              Jump_Valid;
  logic [ADDR_W-1:0] Jump_Target;
  logic              JR_Valid;
  logic              JR_Is_Ret;
  logic [ADDR_W-1:0] JR_Target;
  logic              Call_Valid;
  logic [ADDR_W-1:0] Call_Ret;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PC_plus4;
  logic              Redirect;
  logic              Misalign;
  logic              Ras_Empty;

  modport master (
    output EN, Exc_Valid, Branch_Taken, Branch_Target, Jump_Valid, Jump_Target,
           JR_Valid, JR_Is_Ret, JR_Target, Call_Valid, Call_Ret,
    input  PC, PC_plus4, Redirect, Misalign, Ras_Empty
  );

  modport slave (
    input  EN, Exc_Valid, Branch_Taken, Branch_Target, Jump_Valid, Jump_Target,
           JR_Valid, JR_Is_Ret, JR_Target, Call_Valid, Call_Ret,
    output PC, PC_plus4, Redirect, Misalign, Ras_Empty
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with prioritised redirects and alignment fault reporting.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_0180),
  parameter int unsigned        RAS_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  pc_gen_if.slave      bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, raw_tgt, ras_top;
  logic              redirect_q, redirect_d, misalign_q, misalign_d;
  logic              tgt_hit, pop_hit, ras_empty;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Pick the winning redirect source; the RAS top overrides JR_Target on a return hit
  always_comb begin
    raw_tgt = pc_plus4;
    tgt_hit = 1'b1;
    if (bus.Branch_Taken)    raw_tgt = bus.Branch_Target;
    else if (bus.Jump_Valid) raw_tgt = bus.Jump_Target;
    else if (bus.JR_Valid)   raw_tgt = pop_hit ? ras_top : bus.JR_Target;
    else                     tgt_hit = 1'b0;
  end

  // Next-state: exceptions bypass the stall, everything else waits for EN
  always_comb begin
    pc_d       = pc_q;
    redirect_d = redirect_q;
    misalign_d = misalign_q;
    if (bus.Exc_Valid) begin
      pc_d       = EXC_VEC & ALIGN_MASK;
      redirect_d = 1'b1;
      misalign_d = 1'b0;
    end else if (bus.EN) begin
      if (tgt_hit) begin
        pc_d       = raw_tgt & ALIGN_MASK;
        redirect_d = 1'b1;
        misalign_d = |raw_tgt[1:0];
      end else begin
        pc_d       = pc_plus4;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push;

  assign push      = bus.Call_Valid & bus.EN & ~bus.Exc_Valid & ~bus.Branch_Taken;
  assign pop_hit   = bus.JR_Valid & bus.JR_Is_Ret & bus.EN & ~bus.Exc_Valid &
                     ~bus.Branch_Taken & ~bus.Jump_Valid & (cnt_q != '0);
  assign ras_top   = ras_mem[top_q];
  assign ras_empty = (cnt_q == '0);

  // Circular pointer wraps naturally; a push onto a full stack overwrites the oldest entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (bus.Exc_Valid) begin
      cnt_q <= '0;
    end else if (push && !pop_hit) begin
      top_q <= top_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_hit && !push) begin
      top_q <= top_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Simultaneous push and pop replaces the top entry in place
  always_ff @(posedge CLK) begin
    if (push) ras_mem[pop_hit ? top_q : top_q + PTR_W'(1)] <= bus.Call_Ret;
  end
`else
  logic unused_ras;
  assign unused_ras = ^{bus.Call_Valid, bus.JR_Is_Ret, bus.Call_Ret};
  assign pop_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  assign bus.PC        = pc_q;
  assign bus.PC_plus4  = pc_plus4;
  assign bus.Redirect  = redirect_q;
  assign bus.Misalign  = misalign_q;
  assign bus.Ras_Empty = ras_empty;

endmodule
